// File: rtl/cpu_sequencer_pkg.sv
// Shared CPU definitions: sequencer state encodings and memory opcode constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6
   } state_t;

   localparam logic [3:0] OP_LW = 4'h4;
   localparam logic [3:0] OP_SW = 4'h5;

   // Only loads and stores take the MEM state.
   function automatic logic is_mem_op(input logic [3:0] op);
      return (op == OP_LW) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Memory handshake bundle between the sequencer and the instruction/data memories.
// Latency: n/a (wires only).
// Backpressure: each request is held until its ready arrives.
// master: sequencer side (drives imem_req/dmem_req); slave: memory side (drives the readies).
interface cpu_sequencer_if;

   logic imem_req;
   logic imem_ready;
   logic dmem_req;
   logic dmem_ready;

   modport master (output imem_req, output dmem_req, input imem_ready, input dmem_ready);
   modport slave  (input imem_req, input dmem_req, output imem_ready, output dmem_ready);

endinterface

// File: rtl/seq_wait_timer.sv
// Memory wait-cycle counter; flags the cycle on which a stalled access hits TIMEOUT_CYC.
// Latency: timeout_o is combinational on the TIMEOUT_CYC-th consecutive waiting cycle.
// Backpressure: none; counts while wait_i is high, clears on clr_i.
// Ports: clk, rst_n, wait_i (waiting without ready), clr_i (state change), timeout_o.
module seq_wait_timer #(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic wait_i,
   input  logic clr_i,
   output logic timeout_o
);

   localparam int              CW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // A timeout always forces a state change, so the count never passes LAST.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (wait_i) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign timeout_o = wait_i && (cnt_q == LAST);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: FETCH/DECODE/EXEC/[MEM]/WB with sticky halt request.
// Latency: fetch-to-WB 4 cycles (5 for lw/sw) with zero-wait memories.
// Backpressure: FETCH/MEM hold their request until ready; optional timeout via SEQ_TIMEOUT_EN.
// Ports: clk, rst_n, run, halt_req, opcode, ld_dec, mem (imem/dmem handshakes), ir_ld,
//        ld_out, pc_inc, busy, halted, err, retired.
module cpu_sequencer
   import cpu_sequencer_pkg::*;
#(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   run,
   input  logic                   halt_req,
   input  logic [3:0]             opcode,
   input  logic [6:0]             ld_dec,
   cpu_sequencer_if.master        mem,
   output logic                   ir_ld,
   output logic [6:0]             ld_out,
   output logic                   pc_inc,
   output logic                   busy,
   output logic                   halted,
   output logic                   err,
   output logic [15:0]            retired
);

   state_t      state_q, state_d;
   logic        halt_q;
   logic [15:0] retired_q;
   logic        imem_req_c, dmem_req_c;
   logic        timeout;

`ifdef SEQ_TIMEOUT_EN
   logic err_q;
   logic waiting;

   assign waiting = ((state_q == ST_FETCH) && !mem.imem_ready) ||
                    ((state_q == ST_MEM)   && !mem.dmem_ready);

   // A ready in FETCH/MEM always changes state, so "state change" covers both clears.
   seq_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wait_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .wait_i    (waiting),
      .clr_i     (state_d != state_q),
      .timeout_o (timeout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (timeout) begin
         err_q <= 1'b1;
      end else if ((state_q == ST_HALT) && run) begin
         err_q <= 1'b0;
      end
   end

   assign err = err_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYC;
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      imem_req_c = 1'b0;
      dmem_req_c = 1'b0;
      ir_ld      = 1'b0;
      ld_out     = '0;
      pc_inc     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (run) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            imem_req_c = 1'b1;
            if (mem.imem_ready) begin
               ir_ld   = 1'b1;
               state_d = ST_DECODE;
            end else if (timeout) begin
               state_d = ST_HALT;
            end
         end
         ST_DECODE: state_d = ST_EXEC;
         ST_EXEC:   state_d = is_mem_op(opcode) ? ST_MEM : ST_WB;
         ST_MEM: begin
            dmem_req_c = 1'b1;
            if (mem.dmem_ready) begin
               state_d = ST_WB;
            end else if (timeout) begin
               state_d = ST_HALT;
            end
         end
         ST_WB: begin
            ld_out  = ld_dec;
            pc_inc  = ~ld_dec[0];
            // A request arriving in WB itself still stops after this instruction.
            state_d = (halt_q || halt_req) ? ST_HALT : ST_FETCH;
         end
         ST_HALT: begin
            if (run) state_d = ST_FETCH;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         halt_q    <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         if ((state_q != ST_HALT) && (state_d == ST_HALT)) begin
            halt_q <= 1'b0;
         end else if ((state_q != ST_HALT) && halt_req) begin
            halt_q <= 1'b1;
         end
         if (state_q == ST_WB) begin
            retired_q <= retired_q + 16'd1;
         end
      end
   end

   assign mem.imem_req = imem_req_c;
   assign mem.dmem_req = dmem_req_c;
   assign busy         = (state_q != ST_IDLE) && (state_q != ST_HALT);
   assign halted       = (state_q == ST_HALT);
   assign retired      = retired_q;

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16: memory-wait cycles before the timeout fault (used only with SEQ_TIMEOUT_EN).
REQ-002 SHALL have ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- run  in  1  start/resume request
- halt_req  in  1  stop after the current instruction
- opcode  in  4  instruction bits [15:12] from the instruction register
- ld_dec  in  7  decoder register-load vector: [6:3]=t0..t3, [2]=$p, [1]=memory, [0]=program counter
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data memory request
- ir_ld  out  1  instruction register load strobe
- ld_out  out  7  gated load vector to the datapath
- pc_inc  out  1  program counter +1 strobe
- busy  out  1  not IDLE and not HALT
- halted  out  1  in HALT
- err  out  1  timeout fault flag
- retired  out  16  retired-instruction count

Function
REQ-003 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-004 IDLE SHALL move to FETCH when run=1, and stay in IDLE otherwise.
REQ-005 FETCH SHALL hold imem_req=1 until imem_ready=1, then pulse ir_ld for that cycle and move to DECODE.
REQ-006 DECODE SHALL last exactly one cycle, then move to EXEC.
REQ-007 EXEC SHALL last one cycle, then go to MEM if opcode is lw or sw, else to WB.
REQ-008 MEM SHALL hold dmem_req=1 until dmem_ready=1, then move to WB.
REQ-009 WB SHALL last one cycle, drive ld_out=ld_dec, drive pc_inc=~ld_dec[0], and increment retired (16-bit, wraps 0xFFFF->0x0000).
REQ-010 Outside WB, ld_out SHALL be 0 and pc_inc SHALL be 0.
REQ-011 halt_req SHALL be latched (sticky) in any state other than HALT; after WB, the FSM SHALL go to HALT if the latch is set, else to FETCH.
REQ-012 Entering HALT SHALL clear the halt latch.
REQ-013 HALT SHALL move to FETCH on run=1; run and halt_req asserted together in HALT SHALL resume, and halt_req there SHALL be ignored.
REQ-014 A ready signal arriving in the same cycle as its request is first asserted SHALL complete the access (zero-wait).
REQ-015 imem_ready outside FETCH and dmem_ready outside MEM SHALL be ignored.
REQ-016 Fetch-to-WB latency SHALL be 4 cycles for non-memory instructions and 5 cycles for lw/sw with zero-wait memories.

Reset
REQ-017 rst_n=0 SHALL immediately force state IDLE, clear the halt latch, and set every output to 0 (retired=0, err=0), including when asserted mid-access.
REQ-018 After reset release, the first FETCH SHALL occur only after run is asserted.

Configuration
REQ-019 With SEQ_TIMEOUT_EN defined, a wait counter SHALL count cycles in FETCH/MEM without ready, and SHALL clear on ready and on every state change.
REQ-020 When that counter reaches TIMEOUT_CYC, the FSM SHALL go to HALT with err=1 and no WB.
REQ-021 err SHALL clear when run leaves HALT.
REQ-022 Without SEQ_TIMEOUT_EN, there SHALL be no counter, err SHALL be tied 0, and waits SHALL be unbounded.

Structure
REQ-023 State encodings and opcode constants (lw, sw) SHALL live in the shared CPU definitions package/header; TIMEOUT_CYC SHALL stay local.
REQ-024 The optional wait counter SHALL be one sub-module, seq_wait_timer; the FSM SHALL stay in cpu_sequencer.

Verification
REQ-025 add with ld_dec=7'b1000000, zero-wait memories, run=1 -> ir_ld in cycle 1, ld_out=7'b1000000 and pc_inc=1 in cycle 4, retired=1.
REQ-026 lw with dmem_ready delayed 3 cycles -> dmem_req high for 4 cycles, then one WB cycle with ld_out=ld_dec.
REQ-027 jmp with ld_dec[0]=1 -> WB has pc_inc=0 and ld_out[0]=1.
REQ-028 halt_req pulsed during DECODE -> WB completes, then halted=1; run=1 -> FETCH on the next cycle.
REQ-029 rst_n low during MEM -> all outputs 0 immediately; after release, state stays IDLE until run.
REQ-030 SEQ_TIMEOUT_EN, TIMEOUT_CYC=16, imem_ready held 0 -> halted=1 and err=1 after 16 cycles; run clears err.
